execute_stage: RTL and testbench

- LC-3 pipeline execute stage; the producer side of the writeback interface.
- Takes the decoded instruction, next PC and register-file read values (VSR1/VSR2). Drives sr1/sr2 to the register file.
- Computes ALU results, effective addresses and branch conditions.
- Registers aluout, pcout, dr, W_Control and the writeback enable toward the writeback and memory stages.
- Single-cycle latency; supports operand bypass from the previous ALU result and from the memory stage.

---
 rtl/execute_stage_pkg.sv | 40 ++++
 rtl/execute_stage_if.sv | 23 ++
 rtl/execute_stage_alu.sv | 27 ++
 rtl/execute_stage.sv | 131 +++++++++++++
 tb/tb_execute_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// lc3_pkg: shared LC-3 execute-stage definitions.
//   - opcode constants (IR[15:12])
//   - writeback mux select and memory control encodings
//   - sext(): sign-extend the low 'w' bits of a word to the full datapath width
package lc3_pkg;

  localparam int LC3_DW = 16;
  localparam int LC3_RW = 3;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_NPC = 2'd3;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_IREAD = 2'd2;
  localparam logic [1:0] MEM_WRITE = 2'd3;

  // Move the source field's sign bit to the MSB, then arithmetic-shift back.
  function automatic logic [LC3_DW-1:0] sext(input logic [LC3_DW-1:0] v, input int unsigned w);
    logic [LC3_DW-1:0] t;
    t = v << (LC3_DW - w);
    return $signed(t) >>> (LC3_DW - w);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: registered execute-stage results toward writeback/memory.
//   master: driven by execute_stage.  slave: consumed by downstream stages.
//   aluout, pcout, M_Data, npc_out (16b), dr (3b), NZP (3b),
//   W_Control_out, Mem_Control_out (2b), wb_en, valid_out (1b).
interface execute_stage_if;
  import lc3_pkg::*;

  logic [LC3_DW-1:0] aluout;
  logic [LC3_DW-1:0] pcout;
  logic [LC3_RW-1:0] dr;
  logic [1:0]        W_Control_out;
  logic [1:0]        Mem_Control_out;
  logic              wb_en;
  logic [LC3_DW-1:0] M_Data;
  logic [2:0]        NZP;
  logic [LC3_DW-1:0] npc_out;
  logic              valid_out;

  modport master (output aluout, pcout, dr, W_Control_out, Mem_Control_out,
                  wb_en, M_Data, NZP, npc_out, valid_out);
  modport slave  (input  aluout, pcout, dr, W_Control_out, Mem_Control_out,
                  wb_en, M_Data, NZP, npc_out, valid_out);
endinterface

// File: rtl/execute_stage_alu.sv
// exec_alu: combinational LC-3 ALU (ADD, AND, NOT).
//   a, b   : operands after bypass selection
//   ir     : instruction word; IR[5] selects imm5 in place of b
//   result : ALU result (0 for non-ALU opcodes; caller ignores it then)
module exec_alu
  import lc3_pkg::*;
(
  input  logic [LC3_DW-1:0] a,
  input  logic [LC3_DW-1:0] b,
  input  logic [LC3_DW-1:0] ir,
  output logic [LC3_DW-1:0] result
);

  logic [LC3_DW-1:0] b_sel;

  always_comb begin
    b_sel  = ir[5] ? sext(ir, 5) : b;
    result = '0;
    case (ir[15:12])
      OP_ADD:  result = a + b_sel;
      OP_AND:  result = a & b_sel;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: LC-3 execute stage, producer side of the writeback interface.
//   clock, reset (sync, active-high), enable_execute (low = hold, valid_out drops)
//   IR, npc_in, VSR1, VSR2 : decoded instruction, PC+1, register-file operands
//   Mem_Bypass_Val, bypass_{alu,mem}_{1,2} : operand forwarding (ALU bypass wins)
//   sr1, sr2 : combinational register-file read addresses
//   wb       : registered results (execute_stage_if master)
module execute_stage
  import lc3_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_execute,
  input  logic [DW-1:0] IR,
  input  logic [DW-1:0] npc_in,
  input  logic [DW-1:0] VSR1,
  input  logic [DW-1:0] VSR2,
  input  logic [DW-1:0] Mem_Bypass_Val,
  input  logic          bypass_alu_1,
  input  logic          bypass_alu_2,
  input  logic          bypass_mem_1,
  input  logic          bypass_mem_2,
  output logic [RW-1:0] sr1,
  output logic [RW-1:0] sr2,
  execute_stage_if.master wb
);

  logic [3:0]    opcode;
  logic [DW-1:0] op_a, op_b, alu_res, off6, off9;
  logic [DW-1:0] pc_next;
  logic [RW-1:0] dr_next;
  logic [2:0]    nzp_next;
  logic [1:0]    wctl_next, mctl_next;
  logic          wben_next, is_alu, is_store;

  assign opcode = IR[15:12];
  assign off6   = sext(IR, 6);
  assign off9   = sext(IR, 9);

  always_comb begin
    sr1 = '0;
    sr2 = '0;
    case (opcode)
      OP_ADD, OP_AND: begin sr1 = IR[8:6]; sr2 = IR[2:0]; end
      OP_NOT, OP_JMP, OP_LDR: sr1 = IR[8:6];
      OP_STR: begin sr1 = IR[8:6]; sr2 = IR[11:9]; end
      OP_ST, OP_STI: sr2 = IR[11:9];
      default: ;
    endcase
  end

  // Forwarding: previous ALU result takes precedence over the memory-stage value.
  assign op_a = bypass_alu_1 ? wb.aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1;
  assign op_b = bypass_alu_2 ? wb.aluout : bypass_mem_2 ? Mem_Bypass_Val : VSR2;

  exec_alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .ir     (IR),
    .result (alu_res)
  );

  always_comb begin
    pc_next   = wb.pcout;
    dr_next   = '0;
    nzp_next  = '0;
    wctl_next = WB_ALU;
    mctl_next = MEM_NONE;
    wben_next = 1'b0;
    is_alu    = 1'b0;
    is_store  = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT: begin
        is_alu = 1'b1; wben_next = 1'b1; dr_next = IR[11:9];
      end
      OP_BR:  begin pc_next = npc_in + off9; nzp_next = IR[11:9]; end
      OP_JMP: begin pc_next = op_a; nzp_next = 3'b111; end
      OP_LD, OP_LDI: begin
        pc_next   = npc_in + off9;
        mctl_next = (opcode == OP_LDI) ? MEM_IREAD : MEM_READ;
        wctl_next = WB_MEM; wben_next = 1'b1; dr_next = IR[11:9];
      end
      OP_LDR: begin
        pc_next   = op_a + off6;
        mctl_next = MEM_READ;
        wctl_next = WB_MEM; wben_next = 1'b1; dr_next = IR[11:9];
      end
      OP_LEA: begin
        pc_next = npc_in + off9; wctl_next = WB_PC; wben_next = 1'b1; dr_next = IR[11:9];
      end
      OP_ST, OP_STI: begin
        pc_next = npc_in + off9; mctl_next = MEM_WRITE; is_store = 1'b1;
      end
      OP_STR: begin
        pc_next = op_a + off6; mctl_next = MEM_WRITE; is_store = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb.aluout          <= '0;
      wb.pcout           <= '0;
      wb.dr              <= '0;
      wb.W_Control_out   <= '0;
      wb.Mem_Control_out <= '0;
      wb.wb_en           <= 1'b0;
      wb.M_Data          <= '0;
      wb.NZP             <= '0;
      wb.npc_out         <= '0;
      wb.valid_out       <= 1'b0;
    end else begin
      wb.valid_out <= enable_execute;
      if (enable_execute) begin
        if (is_alu)   wb.aluout <= alu_res;
        if (is_store) wb.M_Data <= op_b;
        wb.pcout           <= pc_next;
        wb.dr              <= dr_next;
        wb.W_Control_out   <= wctl_next;
        wb.Mem_Control_out <= mctl_next;
        wb.wb_en           <= wben_next;
        wb.NZP             <= nzp_next;
        wb.npc_out         <= npc_in;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable_execute;
  logic [15:0] IR, npc_in, VSR1, VSR2, Mem_Bypass_Val;
  logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
  logic [2:0]  sr1, sr2;
  int          checks = 0;
  int          failures = 0;

  execute_stage_if wb ();

  execute_stage dut (
    .clock          (clock),
    .reset          (reset),
    .enable_execute (enable_execute),
    .IR             (IR),
    .npc_in         (npc_in),
    .VSR1           (VSR1),
    .VSR2           (VSR2),
    .Mem_Bypass_Val (Mem_Bypass_Val),
    .bypass_alu_1   (bypass_alu_1),
    .bypass_alu_2   (bypass_alu_2),
    .bypass_mem_1   (bypass_mem_1),
    .bypass_mem_2   (bypass_mem_2),
    .sr1            (sr1),
    .sr2            (sr2),
    .wb             (wb)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_bypass();
    bypass_alu_1 = 0; bypass_alu_2 = 0; bypass_mem_1 = 0; bypass_mem_2 = 0;
  endtask

  task automatic test_reset();
    reset = 1; enable_execute = 0; IR = 16'h0; npc_in = 16'h0;
    VSR1 = 0; VSR2 = 0; Mem_Bypass_Val = 0; clr_bypass();
    tick(); tick();
    reset = 0;
    checks++; if (wb.aluout !== 16'h0) begin failures++; $display("FAIL rst_aluout got=%h exp=0000", wb.aluout); end
    checks++; if (wb.pcout !== 16'h0) begin failures++; $display("FAIL rst_pcout got=%h exp=0000", wb.pcout); end
    checks++; if ({wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en, wb.valid_out} !== 12'h0)
      begin failures++; $display("FAIL rst_ctrl got=%h exp=000", {wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en, wb.valid_out}); end
    checks++; if ({wb.M_Data, wb.npc_out} !== 32'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", {wb.M_Data, wb.npc_out}); end
  endtask

  task automatic test_add();
    @(negedge clock);
    enable_execute = 1; IR = 16'h1283; VSR1 = 16'd5; VSR2 = 16'd7; npc_in = 16'h3000;
    #1;
    checks++; if (sr1 !== 3'd2) begin failures++; $display("FAIL add_sr1 got=%0d exp=2", sr1); end
    checks++; if (sr2 !== 3'd3) begin failures++; $display("FAIL add_sr2 got=%0d exp=3", sr2); end
    tick();
    checks++; if (wb.aluout !== 16'd12) begin failures++; $display("FAIL add_aluout got=%h exp=000c", wb.aluout); end
    checks++; if (wb.dr !== 3'd1 || wb.wb_en !== 1'b1) begin failures++; $display("FAIL add_dr_wben got=%0d/%0d exp=1/1", wb.dr, wb.wb_en); end
    checks++; if (wb.W_Control_out !== 2'd0 || wb.valid_out !== 1'b1) begin failures++; $display("FAIL add_wctl_valid got=%0d/%0d exp=0/1", wb.W_Control_out, wb.valid_out); end
    checks++; if (wb.npc_out !== 16'h3000) begin failures++; $display("FAIL add_npc got=%h exp=3000", wb.npc_out); end
  endtask

  task automatic test_and_not();
    @(negedge clock);
    IR = 16'h56BF; VSR1 = 16'hA5A5; VSR2 = 16'h0000;
    tick();
    checks++; if (wb.aluout !== 16'hA5A5) begin failures++; $display("FAIL and_imm got=%h exp=a5a5", wb.aluout); end
    @(negedge clock);
    IR = 16'h987F; VSR1 = 16'h0000; bypass_alu_1 = 1;
    #1;
    checks++; if (sr1 !== 3'd1 || sr2 !== 3'd0) begin failures++; $display("FAIL not_sr got=%0d/%0d exp=1/0", sr1, sr2); end
    tick();
    clr_bypass();
    checks++; if (wb.aluout !== 16'h5A5A) begin failures++; $display("FAIL not_bypass got=%h exp=5a5a", wb.aluout); end
    checks++; if (wb.dr !== 3'd4) begin failures++; $display("FAIL not_dr got=%0d exp=4", wb.dr); end
  endtask

  task automatic test_branch();
    @(negedge clock);
    IR = 16'h0FFE; npc_in = 16'h3001;
    tick();
    checks++; if (wb.pcout !== 16'h2FFF) begin failures++; $display("FAIL br_pcout got=%h exp=2fff", wb.pcout); end
    checks++; if (wb.NZP !== 3'b111 || wb.wb_en !== 1'b0 || wb.dr !== 3'd0) begin failures++; $display("FAIL br_ctrl got=%b/%0d/%0d exp=111/0/0", wb.NZP, wb.wb_en, wb.dr); end
    checks++; if (wb.aluout !== 16'h5A5A) begin failures++; $display("FAIL br_alu_hold got=%h exp=5a5a", wb.aluout); end
    @(negedge clock);
    IR = 16'hC1C0; VSR1 = 16'h4000;
    #1;
    checks++; if (sr1 !== 3'd7) begin failures++; $display("FAIL jmp_sr1 got=%0d exp=7", sr1); end
    tick();
    checks++; if (wb.pcout !== 16'h4000 || wb.NZP !== 3'b111) begin failures++; $display("FAIL jmp got=%h/%b exp=4000/111", wb.pcout, wb.NZP); end
  endtask

  task automatic test_store();
    @(negedge clock);
    IR = 16'h7A7F; VSR1 = 16'h3000; VSR2 = 16'hBEEF;
    #1;
    checks++; if (sr1 !== 3'd1 || sr2 !== 3'd5) begin failures++; $display("FAIL str_sr got=%0d/%0d exp=1/5", sr1, sr2); end
    tick();
    checks++; if (wb.pcout !== 16'h2FFF) begin failures++; $display("FAIL str_pcout got=%h exp=2fff", wb.pcout); end
    checks++; if (wb.M_Data !== 16'hBEEF) begin failures++; $display("FAIL str_mdata got=%h exp=beef", wb.M_Data); end
    checks++; if (wb.Mem_Control_out !== 2'd3 || wb.wb_en !== 1'b0 || wb.NZP !== 3'd0) begin failures++; $display("FAIL str_ctrl got=%0d/%0d/%b exp=3/0/000", wb.Mem_Control_out, wb.wb_en, wb.NZP); end
  endtask

  task automatic test_load_bypass();
    @(negedge clock);
    IR = 16'h2205; npc_in = 16'h3000; bypass_alu_1 = 1; bypass_mem_1 = 1; Mem_Bypass_Val = 16'h0100;
    tick();
    checks++; if (wb.pcout !== 16'h3005) begin failures++; $display("FAIL ld_pcout got=%h exp=3005", wb.pcout); end
    checks++; if (wb.W_Control_out !== 2'd1 || wb.Mem_Control_out !== 2'd1 || wb.dr !== 3'd1 || wb.wb_en !== 1'b1)
      begin failures++; $display("FAIL ld_ctrl got=%0d/%0d/%0d/%0d exp=1/1/1/1", wb.W_Control_out, wb.Mem_Control_out, wb.dr, wb.wb_en); end
    checks++; if (wb.M_Data !== 16'hBEEF) begin failures++; $display("FAIL ld_mdata_hold got=%h exp=beef", wb.M_Data); end
    @(negedge clock);
    IR = 16'hA402;
    tick();
    checks++; if (wb.pcout !== 16'h3002 || wb.Mem_Control_out !== 2'd2 || wb.dr !== 3'd2)
      begin failures++; $display("FAIL ldi got=%h/%0d/%0d exp=3002/2/2", wb.pcout, wb.Mem_Control_out, wb.dr); end
    @(negedge clock);
    IR = 16'hE1FF;
    tick();
    checks++; if (wb.pcout !== 16'h2FFF || wb.W_Control_out !== 2'd2 || wb.Mem_Control_out !== 2'd0)
      begin failures++; $display("FAIL lea got=%h/%0d/%0d exp=2fff/2/0", wb.pcout, wb.W_Control_out, wb.Mem_Control_out); end
    @(negedge clock);
    IR = 16'h1283; VSR1 = 16'h0002; VSR2 = 16'h0001;
    tick();
    checks++; if (wb.aluout !== 16'h5A5B) begin failures++; $display("FAIL alu_wins_a got=%h exp=5a5b", wb.aluout); end
    checks++; if (wb.pcout !== 16'h2FFF) begin failures++; $display("FAIL alu_pc_hold got=%h exp=2fff", wb.pcout); end
    @(negedge clock);
    clr_bypass(); bypass_mem_2 = 1; Mem_Bypass_Val = 16'h0010;
    tick();
    checks++; if (wb.aluout !== 16'h0012) begin failures++; $display("FAIL mem_bypass_b got=%h exp=0012", wb.aluout); end
    @(negedge clock);
    clr_bypass(); bypass_alu_2 = 1; bypass_mem_2 = 1; VSR1 = 16'h0001;
    tick();
    clr_bypass();
    checks++; if (wb.aluout !== 16'h0013) begin failures++; $display("FAIL alu_wins_b got=%h exp=0013", wb.aluout); end
  endtask

  task automatic test_hold();
    logic [15:0] irs [3];
    irs[0] = 16'h56BF; irs[1] = 16'h0FFE; irs[2] = 16'h7A7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      enable_execute = 0; IR = irs[i]; VSR1 = 16'h1111 * (i + 1); npc_in = 16'h7000;
      tick();
      checks++; if (wb.valid_out !== 1'b0) begin failures++; $display("FAIL hold_valid[%0d] got=%0d exp=0", i, wb.valid_out); end
      checks++; if ({wb.aluout, wb.pcout, wb.M_Data, wb.npc_out} !== {16'h0013, 16'h2FFF, 16'hBEEF, 16'h3000})
        begin failures++; $display("FAIL hold_data[%0d] got=%h exp=00132fffbeef3000", i, {wb.aluout, wb.pcout, wb.M_Data, wb.npc_out}); end
      checks++; if (wb.dr !== 3'd1 || wb.wb_en !== 1'b1 || wb.W_Control_out !== 2'd0)
        begin failures++; $display("FAIL hold_ctrl[%0d] got=%0d/%0d/%0d exp=1/1/0", i, wb.dr, wb.wb_en, wb.W_Control_out); end
    end
  endtask

  task automatic test_nop_and_reset();
    @(negedge clock);
    enable_execute = 1; IR = 16'hDFFF; npc_in = 16'h3000;
    tick();
    checks++; if ({wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en} !== 11'h0 || wb.valid_out !== 1'b1)
      begin failures++; $display("FAIL nop_ctrl got=%h/%0d exp=000/1", {wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en}, wb.valid_out); end
    checks++; if ({wb.aluout, wb.pcout, wb.M_Data} !== {16'h0013, 16'h2FFF, 16'hBEEF})
      begin failures++; $display("FAIL nop_hold got=%h exp=00132fffbeef", {wb.aluout, wb.pcout, wb.M_Data}); end
    @(negedge clock);
    reset = 1; IR = 16'h1283; VSR1 = 16'h0005; VSR2 = 16'h0007;
    tick();
    reset = 0; enable_execute = 0;
    checks++; if ({wb.aluout, wb.pcout, wb.M_Data, wb.npc_out} !== 64'h0)
      begin failures++; $display("FAIL midrst_data got=%h exp=0", {wb.aluout, wb.pcout, wb.M_Data, wb.npc_out}); end
    checks++; if ({wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en, wb.valid_out} !== 12'h0)
      begin failures++; $display("FAIL midrst_ctrl got=%h exp=000", {wb.dr, wb.NZP, wb.W_Control_out, wb.Mem_Control_out, wb.wb_en, wb.valid_out}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_not();
    test_branch();
    test_store();
    test_load_bypass();
    test_hold();
    test_nop_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
